// File: rtl/cpu_prefetch.sv
// cpu_prefetch: instruction fetch front end with a small prefetch queue.
//
// Fetches sequential words over a single-outstanding request/ready bus, buffers
// {pc, instruction} pairs in a DEPTH-entry FIFO and hands them to decode through
// a registered valid/busy handshake. Jumps from execute and interrupt dispatch
// flush the queue and restart fetching at the new target.
//
// Ports:
//   i_clock, i_reset               clock, synchronous active-high reset
//   i_decode_busy                  decode cannot accept o_instruction this cycle
//   i_jump, i_jump_pc              redirect pulse and target
//   i_irq_pending, i_irq_pc        interrupt request and vector
//   o_irq_dispatched, o_irq_epc    one-cycle dispatch pulse and return PC
//   o_bus_request, o_bus_address   instruction bus request and word address
//   i_bus_ready, i_bus_rdata       bus completion and fetched word
//   o_valid, o_instruction, o_pc   entry presented to decode
//   o_tag                          counts instructions accepted by decode
module cpu_prefetch #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_decode_busy,
  input  logic                 i_jump,
  input  logic [31:0]          i_jump_pc,
  input  logic                 i_irq_pending,
  input  logic [31:0]          i_irq_pc,
  output logic                 o_irq_dispatched,
  output logic [31:0]          o_irq_epc,
  output logic                 o_bus_request,
  input  logic                 i_bus_ready,
  output logic [31:0]          o_bus_address,
  input  logic [31:0]          i_bus_rdata,
  output logic                 o_valid,
  output logic [31:0]          o_instruction,
  output logic [31:0]          o_pc,
  output logic [TAG_WIDTH-1:0] o_tag
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StReq     = 2'd1;
  localparam logic [1:0] StDiscard = 2'd2;

  localparam logic [31:0] AlignMask = 32'hFFFF_FFFC;
  localparam logic [31:0] ResetPcAligned = RESET_PC & AlignMask;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] bus_addr_q, bus_addr_d;

  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic                 valid_q;
  logic [31:0]          out_pc_q, out_ins_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 irq_q;
  logic [31:0]          epc_q;

  logic        transfer, irq_take, flush, fifo_empty, pop, push, space;
  logic [31:0] flush_pc, epc;

  // Handshake, flush and FIFO control.
  always_comb begin
    transfer   = valid_q && !i_decode_busy;
    // The dispatched pulse blocks a back-to-back retake while the CSR block
    // is still deasserting its request.
    irq_take   = i_irq_pending && !i_jump && !irq_q;
    flush      = i_jump || irq_take;
    flush_pc   = (i_jump ? i_jump_pc : i_irq_pc) & AlignMask;
    fifo_empty = (count_q == '0);
    pop        = !flush && (!valid_q || transfer) && !fifo_empty;
    push       = (state_q == StReq) && i_bus_ready && !flush;

    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
    // A new request is only launched if its data is guaranteed a FIFO slot.
    space = (count_d < CW'(DEPTH));

    fetch_pc_d = fetch_pc_q;
    if (flush) begin
      fetch_pc_d = flush_pc;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    // Return PC: the oldest instruction that decode has not taken.
    if (valid_q && !transfer) begin
      epc = out_pc_q;
    end else if (!fifo_empty) begin
      epc = pc_mem[rd_ptr_q];
    end else begin
      epc = fetch_pc_q;
    end
  end

  // Bus FSM: one outstanding request; a flushed request must still complete.
  always_comb begin
    state_d    = state_q;
    bus_addr_d = bus_addr_q;
    unique case (state_q)
      StIdle: begin
        if (!flush && space) begin
          state_d    = StReq;
          bus_addr_d = fetch_pc_d;
        end
      end
      StReq: begin
        if (i_bus_ready) begin
          if (!flush && space) begin
            bus_addr_d = fetch_pc_d;
          end else begin
            state_d = StIdle;
          end
        end else if (flush) begin
          state_d = StDiscard;
        end
      end
      StDiscard: begin
        if (i_bus_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= ResetPcAligned;
      bus_addr_q <= ResetPcAligned;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      out_pc_q   <= '0;
      out_ins_q  <= '0;
      tag_q      <= '0;
      irq_q      <= 1'b0;
      epc_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      bus_addr_q <= bus_addr_d;
      count_q    <= count_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end

      if (flush) begin
        valid_q <= 1'b0;
      end else if (pop) begin
        valid_q   <= 1'b1;
        out_pc_q  <= pc_mem[rd_ptr_q];
        out_ins_q <= ins_mem[rd_ptr_q];
      end else if (transfer) begin
        valid_q <= 1'b0;
      end

      // A transfer in a flush cycle was still accepted by decode.
      if (transfer) tag_q <= tag_q + TAG_WIDTH'(1);

      irq_q <= irq_take;
      if (irq_take) epc_q <= epc;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge i_clock) begin
    if (push) begin
      pc_mem[wr_ptr_q]  <= fetch_pc_q;
      ins_mem[wr_ptr_q] <= i_bus_rdata;
    end
  end

  assign o_bus_request    = (state_q != StIdle);
  assign o_bus_address    = bus_addr_q;
  assign o_valid          = valid_q;
  assign o_pc             = out_pc_q;
  assign o_instruction    = out_ins_q;
  assign o_tag            = tag_q;
  assign o_irq_dispatched = irq_q;
  assign o_irq_epc        = epc_q;

endmodule

// File: tb/tb_cpu_prefetch.sv
// Bench for cpu_prefetch: directed scenarios with literal expectations followed
// by randomized traffic, all checked every cycle against a queue-based model.
module tb_cpu_prefetch;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TW    = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1, busy = 1'b0, jump = 1'b0, irq = 1'b0, ready = 1'b0;
  logic [31:0] jpc = '0, ipc = '0, rdata = '0;

  logic          o_irq_dispatched, o_bus_request, o_valid;
  logic [31:0]   o_irq_epc, o_bus_address, o_instruction, o_pc;
  logic [TW-1:0] o_tag;

  cpu_prefetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RPC),
    .TAG_WIDTH(TW)
  ) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_decode_busy   (busy),
    .i_jump          (jump),
    .i_jump_pc       (jpc),
    .i_irq_pending   (irq),
    .i_irq_pc        (ipc),
    .o_irq_dispatched(o_irq_dispatched),
    .o_irq_epc       (o_irq_epc),
    .o_bus_request   (o_bus_request),
    .i_bus_ready     (ready),
    .o_bus_address   (o_bus_address),
    .i_bus_rdata     (rdata),
    .o_valid         (o_valid),
    .o_instruction   (o_instruction),
    .o_pc            (o_pc),
    .o_tag           (o_tag)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t          mq[$];      // words fetched but not yet presented
  bit            m_v;        // an entry is presented to decode
  logic [31:0]   m_pc, m_ins;
  logic [TW-1:0] m_tag;
  bit            m_irq;
  logic [31:0]   m_epc;
  bit            m_out;      // a bus request is outstanding
  bit            m_disc;     // ... and its data will be thrown away
  logic [31:0]   m_addr;     // address of the outstanding request
  logic [31:0]   m_fpc;      // next PC to fetch

  task automatic model_step();
    bit tr, take, fl, acc, was_idle, was_disc;
    logic [31:0] epc, tgt;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_v = 0; m_pc = '0; m_ins = '0; m_tag = '0; m_irq = 0; m_epc = '0;
      m_out = 0; m_disc = 0; m_fpc = RPC; m_addr = RPC;
      return;
    end
    tr   = m_v && !busy;
    take = irq && !jump && !m_irq;
    fl   = jump || take;
    tgt  = (jump ? jpc : ipc) & 32'hFFFF_FFFC;
    if (m_v && !tr)          epc = m_pc;
    else if (mq.size() != 0) epc = mq[0].pc;
    else                     epc = m_fpc;
    acc      = m_out && ready;
    was_idle = !m_out;
    was_disc = m_disc;

    if (tr) m_tag = m_tag + 1'b1;
    m_irq = take;
    if (take) m_epc = epc;

    if (fl) begin
      mq.delete();
      m_v   = 0;
      m_fpc = tgt;
    end else begin
      if ((!m_v || tr) && mq.size() != 0) begin
        e = mq.pop_front();
        m_v = 1; m_pc = e.pc; m_ins = e.ins;
      end else if (tr) begin
        m_v = 0;
      end
      if (acc && !m_disc) begin
        e.pc = m_addr; e.ins = rdata;
        mq.push_back(e);
        m_fpc = m_fpc + 32'd4;
      end
    end

    if (acc) begin
      m_out = 0; m_disc = 0;
    end else if (fl && m_out) begin
      m_disc = 1;
    end
    if (!fl && (was_idle || (acc && !was_disc)) && mq.size() < DEPTH) begin
      m_out  = 1;
      m_addr = m_fpc;
    end
  endtask

  always @(posedge clk) model_step();

  // ---------------- per-cycle compare ----------------
  bit chk_en = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        chk("valid", 32'(o_valid), 32'(m_v));
        chk("tag", 32'(o_tag), 32'(m_tag));
        chk("bus_request", 32'(o_bus_request), 32'(m_out));
        chk("irq_dispatched", 32'(o_irq_dispatched), 32'(m_irq));
        if (m_v) begin
          chk("pc", o_pc, m_pc);
          chk("instruction", o_instruction, m_ins);
        end
        if (m_out) chk("bus_address", o_bus_address, m_addr);
        if (m_irq) chk("irq_epc", o_irq_epc, m_epc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int lat = 1;      // bus ready latency in cycles after a request is seen
  int wcnt = 0;
  bit manual = 0;   // stimulus drives ready/rdata by hand
  int ncycle = 0;

  task automatic step();
    @(posedge clk);
    #2;
    if (!manual) begin
      if (o_bus_request && !rst) begin
        if (ready) wcnt = 0;
        if (wcnt >= lat) begin
          ready = 1'b1;
          rdata = $urandom;
        end else begin
          ready = 1'b0;
          wcnt++;
        end
      end else begin
        ready = 1'b0;
        wcnt  = 0;
      end
    end
    ncycle++;
  endtask

  task automatic do_reset();
    rst = 1'b1; jump = 1'b0; irq = 1'b0; busy = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- directed + random scenarios ----------------
  initial begin
    int fr, fv, nx, c;
    logic [31:0]   xpc [20];
    logic [TW-1:0] xtag[20];
    bit rd, tr, saw_wrap;
    logic [TW-1:0] prev_tag;

    step();
    chk_en = 1;

    // Sequential fetch, decode always ready.
    do_reset();
    chk("rst valid", 32'(o_valid), 32'd0);
    chk("rst tag", 32'(o_tag), 32'd0);
    chk("rst bus_request", 32'(o_bus_request), 32'd0);
    chk("rst irq_dispatched", 32'(o_irq_dispatched), 32'd0);
    chk("rst irq_epc", o_irq_epc, 32'd0);
    chk("rst pc", o_pc, 32'd0);
    chk("rst instruction", o_instruction, 32'd0);
    lat = 1;
    fr = -1; fv = -1; nx = 0;
    for (int i = 0; i < 20; i++) begin xpc[i] = 32'hDEAD_BEEF; xtag[i] = '1; end
    for (c = 0; c < 60 && nx < 3; c++) begin
      rd = ready && o_bus_request;
      tr = o_valid && !busy;
      if (tr) begin xpc[nx] = o_pc; xtag[nx] = o_tag; nx++; end
      if (rd && fr < 0) fr = ncycle;
      step();
      if (o_valid && fv < 0) fv = ncycle;
    end
    chk("seq transfer count", 32'(nx), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("seq pc", xpc[i], 32'(4 * i));
      chk("seq tag before xfer", 32'(xtag[i]), 32'(i));
    end
    chk("seq tag after 3", 32'(o_tag), 32'd3);
    chk("ready->valid latency", 32'(fv - fr), 32'd2);

    // Decode stalled: queue fills and the bus goes quiet.
    do_reset();
    busy = 1'b1;
    lat = 1;
    repeat (20) step();
    chk("stall valid", 32'(o_valid), 32'd1);
    chk("stall pc", o_pc, 32'd0);
    chk("stall bus idle", 32'(o_bus_request), 32'd0);
    busy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("drain valid", 32'(o_valid), 32'd1);
      chk("drain pc", o_pc, 32'(4 * k));
    end

    // Jump while the request to 0x0C is outstanding.
    do_reset();
    lat = 3;
    for (c = 0; c < 100; c++) begin
      if (o_bus_request && o_bus_address == 32'h0C && !ready) break;
      step();
    end
    chk("wait req 0x0C", 32'(o_bus_request && o_bus_address == 32'h0C), 32'd1);
    jump = 1'b1; jpc = 32'h0000_1002;
    step();
    jump = 1'b0;
    chk("discard req held", 32'(o_bus_request), 32'd1);
    chk("discard addr held", o_bus_address, 32'h0C);
    for (c = 0; c < 50; c++) begin
      if (o_bus_request && o_bus_address != 32'h0C) break;
      step();
    end
    chk("post-jump addr", o_bus_address, 32'h1000);
    for (c = 0; c < 50; c++) begin
      if (o_valid) break;
      step();
    end
    chk("post-jump pc", o_pc, 32'h1000);

    // Interrupt with a stalled entry at 0x20.
    do_reset();
    lat = 0;
    for (c = 0; c < 100; c++) begin
      if (o_valid && o_pc == 32'h20) break;
      step();
    end
    chk("wait pc 0x20", 32'(o_valid && o_pc == 32'h20), 32'd1);
    busy = 1'b1; irq = 1'b1; ipc = 32'h100;
    step();
    chk("irq dispatched", 32'(o_irq_dispatched), 32'd1);
    chk("irq epc", o_irq_epc, 32'h20);
    irq = 1'b0; busy = 1'b0;
    step();
    chk("irq pulse one cycle", 32'(o_irq_dispatched), 32'd0);
    for (c = 0; c < 50; c++) begin
      if (o_valid) break;
      step();
    end
    chk("irq vector pc", o_pc, 32'h100);

    // Jump and interrupt together: jump first, interrupt on the next cycle.
    jump = 1'b1; jpc = 32'h200; irq = 1'b1; ipc = 32'h300;
    step();
    chk("jump wins", 32'(o_irq_dispatched), 32'd0);
    jump = 1'b0;
    step();
    chk("irq retried", 32'(o_irq_dispatched), 32'd1);
    chk("irq retried epc", o_irq_epc, 32'h200);
    irq = 1'b0;
    for (c = 0; c < 50; c++) begin
      if (o_valid) break;
      step();
    end
    chk("retried vector pc", o_pc, 32'h300);

    // Reset lands on the same edge as bus ready.
    do_reset();
    lat = 1;
    for (c = 0; c < 60; c++) begin
      if (o_bus_request && o_bus_address == 32'h8) break;
      step();
    end
    manual = 1; ready = 1'b1; rdata = 32'hA5A5_0008; rst = 1'b1;
    step();
    chk("reset valid", 32'(o_valid), 32'd0);
    chk("reset tag", 32'(o_tag), 32'd0);
    chk("reset bus_request", 32'(o_bus_request), 32'd0);
    rst = 1'b0; ready = 1'b0; manual = 0; wcnt = 0;
    for (c = 0; c < 20; c++) begin
      if (o_bus_request) break;
      step();
    end
    chk("restart addr", o_bus_address, RPC);
    for (c = 0; c < 20; c++) begin
      if (o_valid) break;
      step();
    end
    chk("restart pc", o_pc, RPC);

    // Tag wrap over 20 transfers.
    do_reset();
    lat = 0;
    nx = 0; saw_wrap = 0;
    for (c = 0; c < 200 && nx < 20; c++) begin
      if (o_valid && !busy) nx++;
      prev_tag = o_tag;
      step();
      if (prev_tag == 4'd15 && o_tag == 4'd0) saw_wrap = 1;
    end
    chk("wrap transfers", 32'(nx), 32'd20);
    chk("wrap tag", 32'(o_tag), 32'd4);
    chk("wrap seen", 32'(saw_wrap), 32'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) lat = $urandom_range(0, 3);
      rst  = ($urandom % 700 == 0);
      busy = ($urandom % 4 == 0) || ((n / 100) % 5 == 3 && ($urandom % 8 != 0));
      if (!jump && $urandom % 40 == 0) begin
        jump = 1'b1;
        jpc  = $urandom;
      end else begin
        jump = 1'b0;
      end
      if (irq && o_irq_dispatched) begin
        irq = 1'b0;
      end else if (!irq && $urandom % 60 == 0) begin
        irq = 1'b1;
        ipc = $urandom;
      end
      step();
    end
    rst = 1'b0; jump = 1'b0; irq = 1'b0; busy = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_prefetch.md
Name: cpu_prefetch

Overview:
Instruction fetch front end with a small prefetch queue. It sits directly upstream of the decode stage.
- Issues sequential word fetches on the instruction bus and buffers {pc, instruction} pairs in a DEPTH-entry FIFO.
- Presents entries to decode through a registered valid/busy handshake.
- Handles redirects from execute (jump) and interrupt dispatch from the CSR block by flushing and restarting the fetch PC.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of two, 2..16
RESET_PC, 32'h00000000, fetch PC after reset
TAG_WIDTH, 4, width of debug tag counter

Ports:
i_clock  in  1  CPU clock
i_reset  in  1  synchronous active-high reset
i_decode_busy  in  1  decode cannot accept this cycle
i_jump  in  1  redirect request from execute (single-cycle pulse)
i_jump_pc  in  32  redirect target
i_irq_pending  in  1  interrupt waiting in CSR
i_irq_pc  in  32  interrupt vector
o_irq_dispatched  out  1  one-cycle pulse: interrupt taken
o_irq_epc  out  32  PC of first instruction not delivered, valid with o_irq_dispatched
o_bus_request  out  1  instruction bus request
i_bus_ready  in  1  bus data valid / request complete
o_bus_address  out  32  fetch address, word aligned
i_bus_rdata  in  32  fetched instruction
o_valid  out  1  o_instruction/o_pc/o_tag valid for decode
o_instruction  out  32  instruction to decode
o_pc  out  32  PC of o_instruction
o_tag  out  TAG_WIDTH  increments once per instruction handed to decode

Behaviour:
- Clock and reset: one clock (i_clock); reset is synchronous and active-high (i_reset).
- Reset values:
  - o_valid=0, o_bus_request=0, o_irq_dispatched=0, o_tag=0, o_irq_epc=0.
  - o_instruction=0, o_pc=0.
  - FIFO empty, fetch PC=RESET_PC, bus FSM=IDLE.
- Reset mid-transaction: o_bus_request drops the next cycle. A late i_bus_ready is ignored.
- Bus FSM states: IDLE, REQ, DISCARD.
  - IDLE -> REQ when (fifo_count + 1) <= DEPTH after accounting for a same-cycle pop, and no jump/irq this cycle.
  - In REQ: o_bus_request=1 and o_bus_address=fetch PC, both held stable until i_bus_ready.
  - On REQ with i_bus_ready: push {fetch PC, i_bus_rdata} and set fetch PC += 4 (wraps mod 2^32). Go to IDLE, or stay in REQ if space remains; back-to-back requests are allowed.
  - DISCARD: entered when a flush occurs while in REQ. The request and address stay stable until i_bus_ready, the data is dropped (no push), then the FSM goes to IDLE.
- Output register: loaded from the FIFO head when empty or when the current entry transfers.
  - Transfer = o_valid && !i_decode_busy.
  - On transfer, o_tag <= o_tag+1 (wraps).
  - Minimum latency from i_bus_ready to o_valid is 2 cycles: push, then load.
  - Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Jump (i_jump=1), applied next edge:
  - FIFO and output register flushed (o_valid=0).
  - fetch PC <= {i_jump_pc[31:2],2'b00}.
  - In-flight request goes to DISCARD.
  - A transfer occurring in the same cycle still counts (tag increments).
- Interrupt: taken when i_irq_pending && !i_jump && !o_irq_dispatched.
  - o_irq_epc = o_pc if o_valid and no transfer this cycle; else FIFO head pc if FIFO non-empty; else fetch PC.
  - o_irq_dispatched pulses exactly 1 cycle.
  - Flush as for jump, with target i_irq_pc.
  - A jump in the same cycle wins; the irq is retried on a later cycle.
- No bus request is issued in the cycle a flush is applied.
- FIFO occupancy never exceeds DEPTH; outstanding requests are at most 1.

Test Plan:
- Reset, i_bus_ready returned the cycle after every request, decode never busy -> addresses 0,4,8,...; o_pc follows 0,4,8; o_tag 1,2,3; first o_valid 2 cycles after first ready.
- i_decode_busy=1 held for 20 cycles (DEPTH=4) -> o_valid stays at pc 0; exactly 4 further words buffered (pc 4..16); o_bus_request low while full; release -> pcs 4..16 delivered in order with no gaps.
- Jump to 32'h00001002 while a request to 0x0C is pending with 3-cycle ready latency -> address 0x0C held until ready; its data not delivered; next request 0x1000; next o_pc 0x1000.
- i_irq_pending with o_valid=1, o_pc=0x20, decode busy, i_irq_pc=0x100 -> o_irq_dispatched 1 cycle with o_irq_epc=0x20; next delivered o_pc=0x100.
- i_irq_pending and i_jump same cycle (jump 0x200) -> no dispatch that cycle; jump taken; dispatch next cycle with o_irq_epc=0x200.
- Assert i_reset during REQ with i_bus_ready arriving in the reset cycle -> no push; o_valid=0, o_tag=0; fetching restarts at RESET_PC. Also run 20 transfers with TAG_WIDTH=4 -> o_tag wraps 15->0.
